// File: rtl/bram_dp_init_if.sv
// One port of the dual-port RAM: request, write data and registered read response.
interface bram_dp_init_if #(
  parameter int NUM_COL    = 16,
  parameter int COL_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                           en;
  logic [NUM_COL-1:0]             wen;
  logic [ADDR_WIDTH-1:0]          addr;
  logic [NUM_COL*COL_WIDTH-1:0]   din;
  logic [NUM_COL*COL_WIDTH-1:0]   dout;
  logic                           dout_valid;

  modport master (output en, wen, addr, din, input dout, dout_valid);
  modport slave  (input en, wen, addr, din, output dout, dout_valid);
endinterface

// File: rtl/bram_dp_init.sv
// True dual-port block RAM with per-column write enables, a post-reset clear sweep,
// cross-port write-first forwarding and per-port read-valid pipelines.
module bram_dp_init #(
  parameter int                   NUM_COL      = 16,
  parameter int                   COL_WIDTH    = 32,
  parameter int                   ADDR_WIDTH   = 5,
  parameter int                   READ_LATENCY = 1,
  parameter logic [COL_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             init_done,
  bram_dp_init_if.slave    port_a,
  bram_dp_init_if.slave    port_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [NUM_COL-1:0][COL_WIDTH-1:0] word_t;
  typedef logic [NUM_COL-1:0]                mask_t;
  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    init_done_q, init_done_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    init_done_d = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == '1) state_d = S_READY;
      end
      default: init_done_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q     <= S_CLEAR;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;

  // Index 0 is port A, index 1 is port B.
  logic                  en   [2];
  mask_t                 wen  [2];
  logic [ADDR_WIDTH-1:0] addr [2];
  word_t                 din  [2];
  logic                  acc  [2];

  assign en[0]   = port_a.en;
  assign en[1]   = port_b.en;
  assign wen[0]  = port_a.wen;
  assign wen[1]  = port_b.wen;
  assign addr[0] = port_a.addr;
  assign addr[1] = port_b.addr;
  assign din[0]  = port_a.din;
  assign din[1]  = port_b.din;

  // A reset edge never accepts a request, even if init_done was still high.
  assign acc[0] = en[0] & init_done_q & reset_n;
  assign acc[1] = en[1] & init_done_q & reset_n;

  logic same_addr;
  logic clearing;
  assign same_addr = acc[0] & acc[1] & (addr[0] == addr[1]);
  assign clearing  = (state_q == S_CLEAR) & reset_n;

  mask_t                 we_a, we_b;
  logic [ADDR_WIDTH-1:0] waddr_a;
  word_t                 wdata_a;

  // The clear sweep borrows port A's write path; port A wins shared columns.
  always_comb begin
    we_a    = '0;
    we_b    = '0;
    waddr_a = addr[0];
    wdata_a = din[0];
    if (clearing) begin
      we_a    = '1;
      waddr_a = clr_addr_q;
      wdata_a = {NUM_COL{INIT_VALUE}};
    end else begin
      if (acc[0]) we_a = wen[0];
      if (acc[1]) we_b = wen[1] & ~(same_addr ? wen[0] : '0);
    end
  end

  word_t mem [DEPTH];

  // NOTE: the array itself has no reset; the clear sweep initialises it so it still maps to block RAM.
  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_COL; c++) begin
      if (we_a[c]) mem[waddr_a][c] <= wdata_a[c];
      if (we_b[c]) mem[addr[1]][c] <= din[1][c];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int O = 1 - p;

    word_t raw_q;
    mask_t fwd_mask_q, fwd_mask_d;
    word_t fwd_data_q;
    logic  v1_q;
    word_t data1;
    word_t dout2_q;
    logic  v2_q;
    word_t dout_o;
    logic  valid_o;

    // Forward only columns the other port actually stores and this port leaves alone.
    assign fwd_mask_d = same_addr ? (wen[O] & ~wen[p]) : '0;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        raw_q      <= '0;
        fwd_mask_q <= '0;
        fwd_data_q <= '0;
        v1_q       <= 1'b0;
      end else begin
        v1_q <= acc[p];
        if (acc[p]) begin
          raw_q      <= mem[addr[p]];
          fwd_mask_q <= fwd_mask_d;
          fwd_data_q <= din[O];
        end
      end
    end

    always_comb begin
      data1 = raw_q;
      for (int c = 0; c < NUM_COL; c++) begin
        if (fwd_mask_q[c]) data1[c] = fwd_data_q[c];
      end
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        dout2_q <= '0;
        v2_q    <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) dout2_q <= data1;
      end
    end

    assign dout_o  = (READ_LATENCY == 2) ? dout2_q : data1;
    assign valid_o = (READ_LATENCY == 2) ? v2_q    : v1_q;
  end

  assign port_a.dout       = g_port[0].dout_o;
  assign port_a.dout_valid = g_port[0].valid_o;
  assign port_b.dout       = g_port[1].dout_o;
  assign port_b.dout_valid = g_port[1].valid_o;

endmodule

// File: tb/tb_bram_dp_init.sv
// Directed bench for bram_dp_init: clear sweep timing, table-driven port vectors,
// back-to-back reads and reset with reads in flight.
module tb_bram_dp_init;
  localparam int          NC   = 16;
  localparam int          CW   = 32;
  localparam int          AW   = 5;
  localparam int          RL   = 1;
  localparam int          W    = NC * CW;
  localparam logic [31:0] INIT = 32'h5A5A_0F0F;

  typedef logic [NC-1:0][CW-1:0] word_t;

  typedef struct {
    logic           ea;
    logic [NC-1:0]  wa;
    logic [AW-1:0]  aa;
    word_t          da;
    logic           eb;
    logic [NC-1:0]  wb;
    logic [AW-1:0]  ab;
    word_t          db;
    word_t          xa;
    word_t          xb;
    string          nm;
  } vec_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic init_done;

  bram_dp_init_if #(.NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW)) if_a ();
  bram_dp_init_if #(.NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW)) if_b ();

  bram_dp_init #(
    .NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW),
    .READ_LATENCY(RL), .INIT_VALUE(INIT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .init_done(init_done),
    .port_a(if_a),
    .port_b(if_b)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic word_t fill(input logic [31:0] v);
    word_t w;
    for (int c = 0; c < NC; c++) w[c] = v;
    return w;
  endfunction

  function automatic word_t put(input word_t w, input int c, input logic [31:0] v);
    word_t r;
    r    = w;
    r[c] = v;
    return r;
  endfunction

  task automatic drive(input logic ea, input logic [NC-1:0] wa, input logic [AW-1:0] aa,
                       input word_t da, input logic eb, input logic [NC-1:0] wb,
                       input logic [AW-1:0] ab, input word_t db);
    if_a.en = ea; if_a.wen = wa; if_a.addr = aa; if_a.din = da;
    if_b.en = eb; if_b.wen = wb; if_b.addr = ab; if_b.din = db;
  endtask

  task automatic idle();
    if_a.en = 1'b0; if_a.wen = '0;
    if_b.en = 1'b0; if_b.wen = '0;
  endtask

  // Starts right after reset_n went high; the next edge is the first one sampling it high.
  task automatic wait_init(input bit pulse);
    int seen;
    seen = 0;
    for (int i = 1; i <= 2 ** AW + 1; i++) begin
      if (pulse && i >= 25 && i <= 32)
        drive(1'b1, '1, 5'd2, fill(32'hFFFF_0000), 1'b0, '0, '0, '0);
      else
        idle();
      step();
      if (if_a.dout_valid || if_b.dout_valid) seen++;
      if (i == 2 ** AW) check("init_done low at last clear edge", W'(init_done), '0);
    end
    check("init_done high one edge later", W'(init_done), W'(1));
    check("no dout_valid during clear", W'(seen), '0);
  endtask

  task automatic rd(input bit pb, input int a, input word_t exp, input string nm);
    idle();
    if (pb) begin if_b.en = 1'b1; if_b.addr = AW'(a); end
    else    begin if_a.en = 1'b1; if_a.addr = AW'(a); end
    step();
    idle();
    repeat (RL - 1) step();
    check({nm, " valid"}, W'(pb ? if_b.dout_valid : if_a.dout_valid), W'(1));
    check(nm, pb ? if_b.dout : if_a.dout, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  v [12];
    word_t iw, a5, exp_q [3];
    logic [AW-1:0] seq_addr [3];

    iw = fill(INIT);
    a5 = fill(32'hA5A5_A5A5);

    v[0]  = '{1, '1, 3, a5, 0, '0, 0, '0, iw, '0, "wr A addr3 full"};
    v[1]  = '{0, '0, 0, '0, 1, '0, 3, '0, '0, a5, "rd B addr3"};
    v[2]  = '{1, 16'h0001, 4, put(fill(32'hFFFF_FFFF), 0, 32'hDEAD_BEEF), 0, '0, 0, '0, iw, '0, "wr A col0 addr4"};
    v[3]  = '{1, '0, 4, '0, 0, '0, 0, '0, put(iw, 0, 32'hDEAD_BEEF), '0, "rd A addr4 partial"};
    v[4]  = '{1, 16'h0001, 7, put(fill(32'hAAAA_AAAA), 0, 32'h11), 1, 16'h0003, 7,
              put(put(fill(32'hBBBB_BBBB), 0, 32'h22), 1, 32'h33), put(iw, 1, 32'h33), iw, "dual wr addr7"};
    v[5]  = '{0, '0, 0, '0, 1, '0, 7, '0, '0, put(put(iw, 0, 32'h11), 1, 32'h33), "rd B addr7 merged"};
    v[6]  = '{1, 16'h0004, 9, put(fill(32'hCCCC_CCCC), 2, 32'h55), 1, '0, 9, '0, iw, put(iw, 2, 32'h55), "A wr B rd addr9"};
    v[7]  = '{1, '0, 9, '0, 1, '0, 4, '0, put(iw, 2, 32'h55), put(iw, 0, 32'hDEAD_BEEF), "rd A9 B4"};
    v[8]  = '{1, '1, 10, fill(32'h1234_5678), 1, '1, 11, fill(32'h9ABC_DEF0), iw, iw, "indep wr 10/11"};
    v[9]  = '{1, '0, 11, '0, 1, '0, 10, '0, fill(32'h9ABC_DEF0), fill(32'h1234_5678), "rd A11 B10"};
    v[10] = '{1, '1, 3, fill(32'h0F0F_0F0F), 0, '0, 0, '0, a5, '0, "A rd-first addr3"};
    v[11] = '{1, '0, 3, '0, 1, '0, 3, '0, fill(32'h0F0F_0F0F), fill(32'h0F0F_0F0F), "rd both addr3"};

    idle();
    if_a.addr = '0; if_a.din = '0; if_b.addr = '0; if_b.din = '0;
    repeat (3) step();
    check("reset init_done", W'(init_done), '0);
    check("reset valid_a", W'(if_a.dout_valid), '0);
    check("reset valid_b", W'(if_b.dout_valid), '0);
    check("reset dout_a", if_a.dout, '0);
    check("reset dout_b", if_b.dout, '0);

    reset_n = 1'b1;
    wait_init(1'b1);

    for (int a = 0; a < 2 ** AW; a++)
      rd(a[0], a, iw, $sformatf("cleared addr%0d", a));

    for (int i = 0; i < 12; i++) begin
      drive(v[i].ea, v[i].wa, v[i].aa, v[i].da, v[i].eb, v[i].wb, v[i].ab, v[i].db);
      step();
      idle();
      repeat (RL - 1) step();
      check({v[i].nm, " valid_a"}, W'(if_a.dout_valid), W'(v[i].ea));
      check({v[i].nm, " valid_b"}, W'(if_b.dout_valid), W'(v[i].eb));
      if (v[i].ea) check({v[i].nm, " dout_a"}, if_a.dout, v[i].xa);
      if (v[i].eb) check({v[i].nm, " dout_b"}, if_b.dout, v[i].xb);
    end

    // Back-to-back reads on port A, then hold after the last valid.
    seq_addr[0] = 5'd4;  exp_q[0] = put(iw, 0, 32'hDEAD_BEEF);
    seq_addr[1] = 5'd9;  exp_q[1] = put(iw, 2, 32'h55);
    seq_addr[2] = 5'd11; exp_q[2] = fill(32'h9ABC_DEF0);
    for (int k = 0; k <= 2 + RL; k++) begin
      int idx;
      if (k < 3) drive(1'b1, '0, seq_addr[k], '0, 1'b0, '0, '0, '0);
      else       idle();
      step();
      idx = k - (RL - 1);
      if (idx >= 0 && idx < 3) begin
        check($sformatf("b2b valid %0d", idx), W'(if_a.dout_valid), W'(1));
        check($sformatf("b2b dout %0d", idx), if_a.dout, exp_q[idx]);
      end else if (idx == 3) begin
        check("b2b valid drops", W'(if_a.dout_valid), '0);
        check("b2b dout holds", if_a.dout, exp_q[2]);
      end
    end

    // Reset with reads accepted but not yet fully delivered.
    drive(1'b1, '0, 5'd3, '0, 1'b1, '0, 5'd10, '0);
    step();
    idle();
    reset_n = 1'b0;
    step();
    check("mid reset valid_a", W'(if_a.dout_valid), '0);
    check("mid reset valid_b", W'(if_b.dout_valid), '0);
    check("mid reset init_done", W'(init_done), '0);
    check("mid reset dout_a", if_a.dout, '0);
    reset_n = 1'b1;
    wait_init(1'b0);
    rd(1'b0, 3,  iw, "recleared addr3");
    rd(1'b1, 10, iw, "recleared addr10");
    rd(1'b0, 7,  iw, "recleared addr7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
